data_mem_arbiter: RTL
=====================

# data_mem_arbiter

Two-requester arbiter and sequencer for the LC3 data-memory port. It accepts read/write requests from requester 0 (LC3 MemAccess path) and requester 1 (debug/DMA path). It grants one at a time using round-robin priority and drives the data_mem bus: Data_en, Data_rd, Data_addr, Data_din. It holds the access until complete_data, then returns Data_dout or a write acknowledge to the granted requester.

## Interface
- TIMEOUT_CYCLES, 16: cycles in ACCESS without complete_data before abort; legal range 2..255.
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  request pending.
- req0_rd / req1_rd  in  1  1 = read, 0 = write.
- req0_addr / req1_addr  in  16  word address.
- req0_wdata / req1_wdata  in  16  write data.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- rsp0_valid / rsp1_valid  out  1  one-cycle response strobe.
- rsp0_rdata / rsp1_rdata  out  16  read data; 0 for writes and aborts.
- rsp0_err / rsp1_err  out  1  access aborted by timeout.
- Data_en  out  1  memory access active.
- Data_rd  out  1  read/write select to memory.
- Data_addr  out  16  memory address.
- Data_din  out  16  write data to memory.
- Data_dout  in  16  read data from memory.
- complete_data  in  1  memory access done.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - readyN is combinational: readyN = reqN_valid AND grantN.
  - Arbitration: if only one requester is valid, it wins. If both are valid, the requester not granted last wins.
  - last_grant resets to 1, so req0 wins the first tie.
  - On valid&&ready, capture rd, addr and wdata, update last_grant, and go to ACCESS.
- ACCESS:
  - Data_en=1; Data_rd/Data_addr/Data_din come from the captured registers and stay stable for the whole state.
  - When complete_data is sampled high: capture Data_dout (read) or 0 (write), then go to RESP.
- RESP:
  - rspN_valid=1 for exactly one cycle to the granted requester, with rdata and err from registers.
  - Return to IDLE. No new grant is made in RESP.
- complete_data in IDLE or RESP is ignored.
- The non-granted requester sees ready=0 and rsp_valid=0 throughout.
- Outputs are registered except readyN.
- Reset values: Data_en=0, Data_rd=0, Data_addr=0, Data_din=0, rsp*_valid=0, rsp*_rdata=0, rsp*_err=0, state=IDLE.
- Reset asserted mid-access returns all outputs to reset values immediately. The in-flight access is dropped with no response.

## Timing
- Accept edge T: Data_en is high from T+1.
- Best case: complete_data high at T+1 edge, rsp_valid at T+2, earliest next accept at T+3.
- Best-case request-to-response latency is 3 cycles; fair throughput is one access per 3 + memory-wait cycles.
- A requester holding valid through a loss is granted on the next IDLE cycle. Starvation is bounded to one access.

## Configuration
- DATA_MEM_ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle.
  - When it reaches TIMEOUT_CYCLES with complete_data still low: go to RESP with err=1, rdata=0.
  - complete_data on the same cycle as the timeout wins (normal completion).
- Macro undefined: no counter, ACCESS waits indefinitely, rsp*_err tied 0.

## Structure
- data_mem_arb_pkg holds:
  - state enum data_mem_arb_state_e (IDLE, ACCESS, RESP);
  - request struct data_mem_req_s (rd, addr, wdata);
  - localparam DATA_MEM_ARB_NUM_REQ=2.
- One sub-module: data_mem_rr_arbiter. It is a 2-way round-robin grant with the last_grant register, enabled only in IDLE.

## Test plan
- Single read: req0 read at addr 0x3000, memory asserts complete_data 2 cycles after Data_en with Data_dout=0xBEEF -> rsp0_valid for one cycle, rsp0_rdata=0xBEEF, err=0, Data_rd=1 throughout ACCESS.
- Write: req1 writes 0x1234 to 0x4001 -> Data_rd=0, Data_din=0x1234, Data_addr=0x4001 stable until complete_data, rsp1_valid with rdata=0.
- Contention: both valid continuously for 4 accesses after reset -> grant order 0,1,0,1.
- Timeout, macro on, TIMEOUT_CYCLES=4: complete_data never asserted -> rsp0_err=1 after 4 ACCESS cycles, rdata=0, FSM back in IDLE. With macro off, Data_en stays high.
- Reset mid-access: deassert reset during ACCESS -> Data_en=0 immediately, no rsp_valid. After release, a new request completes normally.
- Spurious complete_data in IDLE -> no state change, no response.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// data_mem_arb_pkg: shared types for the data-memory arbiter
package data_mem_arb_pkg;
  localparam int DATA_MEM_ARB_NUM_REQ = 2;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} data_mem_arb_state_e;
  typedef struct packed {
    logic        rd;
    logic [15:0] addr;
    logic [15:0] wdata;
  } data_mem_req_s;
endpackage

// File: rtl/data_mem_rr_arbiter.sv
// data_mem_rr_arbiter: 2-way round-robin grant, evaluated only while en is high
module data_mem_rr_arbiter
  import data_mem_arb_pkg::*;
(
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            en,
  input  logic [DATA_MEM_ARB_NUM_REQ-1:0] valid,
  output logic [DATA_MEM_ARB_NUM_REQ-1:0] grant
);
  logic last_grant;
  // On a tie the requester that did not win last time takes the port
  assign grant = !en ? 2'b00 : &valid ? (last_grant ? 2'b01 : 2'b10) : valid;
  always_ff @(posedge clock or negedge reset)
    if (!reset) last_grant <= 1'b1;
    else if (|grant) last_grant <= grant[1];
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-requester round-robin sequencer for the LC3 data-memory port
// Optional ACCESS timeout abort enabled by defining DATA_MEM_ARB_TIMEOUT_EN.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req0_rd,
  input  logic [15:0] req0_addr,
  input  logic [15:0] req0_wdata,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_rd,
  input  logic [15:0] req1_addr,
  input  logic [15:0] req1_wdata,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic [15:0] rsp0_rdata,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  output logic [15:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic        Data_en,
  output logic        Data_rd,
  output logic [15:0] Data_addr,
  output logic [15:0] Data_din,
  input  logic [15:0] Data_dout,
  input  logic        complete_data
);
  data_mem_arb_state_e state, state_n;
  data_mem_req_s sel, req_q;
  logic [DATA_MEM_ARB_NUM_REQ-1:0] grant, rsp_v;
  logic gnt_q, accept, done, timeout, err_q;
  logic [15:0] rdata_q;
  data_mem_rr_arbiter u_rr (
    .clock(clock),
    .reset(reset),
    .en(state == IDLE),
    .valid({req1_valid, req0_valid}),
    .grant(grant)
  );
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept = |grant;
  assign sel = grant[1] ? data_mem_req_s'{req1_rd, req1_addr, req1_wdata}
                        : data_mem_req_s'{req0_rd, req0_addr, req0_wdata};
`ifdef DATA_MEM_ARB_TIMEOUT_EN
  logic [7:0] cnt;
  // Counts ACCESS cycles already spent; zero on the first ACCESS cycle
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt <= 8'd0;
    else cnt <= state == ACCESS ? cnt + 8'd1 : 8'd0;
  assign timeout = cnt == 8'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif
  assign done = state == ACCESS && (complete_data || timeout);
  always_comb begin
    state_n = state;
    if (state == IDLE && accept) state_n = ACCESS;
    if (done) state_n = RESP;
    if (state == RESP) state_n = IDLE;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      Data_en <= 1'b0;
      req_q   <= '0;
      gnt_q   <= 1'b0;
      rsp_v   <= '0;
      rdata_q <= 16'h0;
      err_q   <= 1'b0;
    end else begin
      rsp_v <= '0;
      if (accept) begin
        Data_en <= 1'b1;
        req_q   <= sel;
        gnt_q   <= grant[1];
      end
      if (done) begin
        Data_en <= 1'b0;
        rsp_v   <= gnt_q ? 2'b10 : 2'b01;
        rdata_q <= req_q.rd && complete_data ? Data_dout : 16'h0;
        err_q   <= !complete_data;
      end
    end
  assign Data_rd    = req_q.rd;
  assign Data_addr  = req_q.addr;
  assign Data_din   = req_q.wdata;
  assign rsp0_valid = rsp_v[0];
  assign rsp1_valid = rsp_v[1];
  assign rsp0_rdata = rdata_q;
  assign rsp1_rdata = rdata_q;
  assign rsp0_err   = err_q;
  assign rsp1_err   = err_q;
endmodule
